camac_cycle_sequencer: RTL and testbench

CAMAC_CYCLE_SEQUENCER -- requirements
Module: camac_cycle_sequencer

---
 rtl/camac_cycle_sequencer_if.sv | 31 +++
 rtl/camac_cycle_sequencer.sv | 104 ++++++++++
 tb/tb_camac_cycle_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/camac_cycle_sequencer_if.sv
// rtl/camac_cycle_sequencer_if.sv - requester, automate and status signals of the CAMAC cycle sequencer
interface camac_cycle_sequencer_if;
  logic       req0;
  logic       req1;
  logic [1:0] req0_a;
  logic [1:0] req1_a;
  logic       req0_w;
  logic       req1_w;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [1:0] a;
  logic       w;
  logic       sel;
  logic       rdy;
  logic       busy;
  logic       err_timeout;

  // sequencer side
  modport master (
    input  req0, req1, req0_a, req1_a, req0_w, req1_w, rdy,
    output gnt0, gnt1, done0, done1, a, w, sel, busy, err_timeout
  );

  // requesters and automate side
  modport slave (
    output req0, req1, req0_a, req1_a, req0_w, req1_w, rdy,
    input  gnt0, gnt1, done0, done1, a, w, sel, busy, err_timeout
  );
endinterface

// File: rtl/camac_cycle_sequencer.sv
// rtl/camac_cycle_sequencer.sv - two-requester round-robin CAMAC cycle sequencer (optional CAMAC_CYCLE_TIMEOUT_EN abort)
module camac_cycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SETUP_CYCLES   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  camac_cycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, ARB, SETUP, STROBE, WAIT_RDY, RELEASE} state_t;

  state_t     state;
  state_t     state_next;
  logic       owner;      // requester holding the current grant
  logic       last;       // requester served most recently
  logic [2:0] setup_cnt;  // cycles already spent in SETUP
  logic [1:0] a_q;
  logic       w_q;
  logic       pick;
  logic       tmo_hit;

  // with both requests pending the one not served last wins
  assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;

`ifdef CAMAC_CYCLE_TIMEOUT_EN
  logic [7:0] tmo_cnt;  // sel-low cycles elapsed, the strobe cycle counts as the first
  logic       tmo_flag;

  // abort counter: cleared entering STROBE, counts while sel is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt  <= 8'd0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == SETUP && state_next == STROBE)
        tmo_cnt <= 8'd0;
      else if (state == STROBE || state == WAIT_RDY)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (state == ARB)
        tmo_flag <= 1'b0;
      else if (state == WAIT_RDY && tmo_hit && !bus.rdy)
        tmo_flag <= 1'b1;
    end
  end

  assign tmo_hit         = (tmo_cnt >= 8'(TIMEOUT_CYCLES - 1));
  assign bus.err_timeout = (state == RELEASE) && tmo_flag;
`else
  assign tmo_hit         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // state register; reset returns to IDLE at once so sel rises without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next state and strobe/grant outputs decoded from the current state
  always_comb begin
    state_next = state;
    bus.busy   = (state != IDLE);
    bus.sel    = !(state == STROBE || state == WAIT_RDY);
    bus.gnt0   = (state != IDLE) && !owner;
    bus.gnt1   = (state != IDLE) && owner;
    bus.done0  = (state == RELEASE) && !owner;
    bus.done1  = (state == RELEASE) && owner;
    bus.a      = a_q;
    bus.w      = w_q;
    case (state)
      IDLE:     if (bus.req0 || bus.req1) state_next = ARB;
      ARB:      state_next = SETUP;
      SETUP:    if (setup_cnt == 3'(SETUP_CYCLES - 1)) state_next = STROBE;
      STROBE:   state_next = WAIT_RDY;
      WAIT_RDY: if (bus.rdy || tmo_hit) state_next = RELEASE;
      RELEASE:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // grant owner, latched address/direction, setup timer and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      a_q       <= 2'd0;
      w_q       <= 1'b0;
      setup_cnt <= 3'd0;
    end else begin
      if (state == IDLE && state_next == ARB)
        owner <= pick;
      if (state == ARB) begin
        a_q <= owner ? bus.req1_a : bus.req0_a;
        w_q <= owner ? bus.req1_w : bus.req0_w;
      end
      if (state == SETUP) setup_cnt <= setup_cnt + 3'd1;
      else                setup_cnt <= 3'd0;
      if (state == RELEASE)
        last <= owner;
    end
  end

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
// tb/tb_camac_cycle_sequencer.sv - self-checking bench for camac_cycle_sequencer
module tb_camac_cycle_sequencer;
  localparam int S = 2;
`ifdef CAMAC_CYCLE_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_served;

  camac_cycle_sequencer_if bus ();

  camac_cycle_sequencer #(.TIMEOUT_CYCLES(TMO), .SETUP_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int winner(input logic r0, input logic r1);
    if (r0 && r1) return (last_served == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  task automatic set_req(input int id, input logic v);
    if (id == 0) bus.req0 = v;
    else         bus.req1 = v;
  endtask

  task automatic raise_other(input int id);
    if (id == 0 && !bus.req1) begin
      bus.req1_a = 2'($urandom); bus.req1_w = 1'($urandom); bus.req1 = 1'b1;
    end else if (id == 1 && !bus.req0) begin
      bus.req0_a = 2'($urandom); bus.req0_w = 1'($urandom); bus.req0 = 1'b1;
    end
  endtask

  // called in the ARB cycle; a cycle ends with done at cycle S+4+d, d = extra WAIT_RDY cycles
  task automatic txn(input int id, input logic [1:0] ea, input logic ew, input int d,
                     input bit rdy_hold, input bit keep, input int drop_at,
                     input int raise_at, input bit tmo);
    int last_c;
    last_c = S + 4 + d;
    for (int c = 1; c <= last_c; c++) begin
      bit lo;
      lo = (c >= S + 2) && (c <= S + 3 + d);
      chk("gnt_own",    (id == 0) ? bus.gnt0 : bus.gnt1, 8'd1);
      chk("gnt_other",  (id == 0) ? bus.gnt1 : bus.gnt0, 8'd0);
      chk("busy",       bus.busy, 8'd1);
      if (c >= 2) begin
        chk("a", bus.a, ea);
        chk("w", bus.w, ew);
      end
      chk("sel",        bus.sel, !lo);
      chk("done_own",   (id == 0) ? bus.done0 : bus.done1, c == last_c);
      chk("done_other", (id == 0) ? bus.done1 : bus.done0, 8'd0);
      chk("err_timeout", bus.err_timeout, tmo && (c == last_c));
      if (c == drop_at) set_req(id, 1'b0);
      if (c == raise_at) raise_other(id);
      if (c == last_c && !keep) set_req(id, 1'b0);
      if (tmo)           bus.rdy = 1'b0;
      else if (rdy_hold) bus.rdy = 1'b1;
      else if (c < S + 3) bus.rdy = 1'($urandom);
      else               bus.rdy = (c == S + 3 + d);
      step();
    end
    chk("idle_busy", bus.busy, 8'd0);
    chk("idle_gnt",  {bus.gnt1, bus.gnt0}, 8'd0);
    chk("idle_done", {bus.done1, bus.done0}, 8'd0);
    chk("idle_sel",  bus.sel, 8'd1);
    last_served = id;
  endtask

  initial begin
    int wn;
    int d;
    int drop;
    int raise;
    logic [1:0] ea;
    logic ew;

    bus.req0 = 0; bus.req1 = 0; bus.req0_a = 0; bus.req1_a = 0;
    bus.req0_w = 0; bus.req1_w = 0; bus.rdy = 0;
    reset = 1'b1;
    last_served = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",  bus.sel, 8'd1);
    chk("rst_a",    bus.a, 8'd0);
    chk("rst_w",    bus.w, 8'd0);
    chk("rst_gnt",  {bus.gnt1, bus.gnt0}, 8'd0);
    chk("rst_done", {bus.done1, bus.done0}, 8'd0);
    chk("rst_busy", bus.busy, 8'd0);
    chk("rst_err",  bus.err_timeout, 8'd0);
    reset = 1'b0;
    step();

    // single write from requester 0 with rdy tied high
    bus.req0_a = 2'd2; bus.req0_w = 1'b1; bus.req0 = 1'b1; bus.rdy = 1'b1;
    step();
    txn(0, 2'd2, 1'b1, 0, 1, 0, 0, 0, 0);

    // contention right after reset: 0, 1, 0, 1
    reset = 1'b1; step(); reset = 1'b0; last_served = 1;
    bus.req0_a = 2'd1; bus.req0_w = 1'b0; bus.req1_a = 2'd3; bus.req1_w = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    txn(0, 2'd1, 1'b0, 0, 1, 1, 0, 0, 0);
    step();
    txn(1, 2'd3, 1'b1, 0, 1, 1, 0, 0, 0);
    step();
    txn(0, 2'd1, 1'b0, 0, 1, 0, 0, 0, 0);
    step();
    txn(1, 2'd3, 1'b1, 0, 1, 0, 0, 0, 0);

    // req0 dropped during SETUP with rdy already high
    bus.req0_a = 2'd1; bus.req0_w = 1'b1; bus.req0 = 1'b1; bus.rdy = 1'b1;
    step();
    txn(0, 2'd1, 1'b1, 0, 1, 0, 2, 0, 0);
    step();
    chk("stay_idle", bus.busy, 8'd0);

    // reset while requester 1 waits for rdy
    bus.rdy = 1'b0; bus.req1_a = 2'd2; bus.req1_w = 1'b0; bus.req1 = 1'b1;
    step();
    repeat (S + 2) step();
    chk("wait_sel",  bus.sel, 8'd0);
    chk("wait_gnt1", bus.gnt1, 8'd1);
    reset = 1'b1;
    #1;
    chk("arst_sel",  bus.sel, 8'd1);
    chk("arst_busy", bus.busy, 8'd0);
    chk("arst_gnt1", bus.gnt1, 8'd0);
    chk("arst_done", {bus.done1, bus.done0}, 8'd0);
    step();
    chk("arst_done2", {bus.done1, bus.done0}, 8'd0);
    reset = 1'b0; last_served = 1;
    bus.req0_a = 2'd3; bus.req0_w = 1'b0; bus.req0 = 1'b1;
    step();
    txn(winner(1'b1, 1'b1), 2'd3, 1'b0, 1, 0, 0, 0, 0, 0);
    step();
    txn(1, 2'd2, 1'b0, 2, 0, 0, 0, 0, 0);

    // randomized traffic against the round-robin model
    for (int n = 0; n < 24; n++) begin
      if (!bus.req0 && $urandom_range(0, 1) == 1) raise_other(1);
      if (!bus.req1 && $urandom_range(0, 1) == 1) raise_other(0);
      if (!bus.req0 && !bus.req1) raise_other(1);
      wn = winner(bus.req0, bus.req1);
      ea = (wn == 1) ? bus.req1_a : bus.req0_a;
      ew = (wn == 1) ? bus.req1_w : bus.req0_w;
      d = $urandom_range(0, 3);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S + 3) : 0;
      raise = $urandom_range(1, S + 4 + d);
      step();
      txn(wn, ea, ew, d, 0, 0, drop, raise, 0);
    end
    for (int k = 0; k < 3; k++) begin
      if (bus.req0 || bus.req1) begin
        wn = winner(bus.req0, bus.req1);
        ea = (wn == 1) ? bus.req1_a : bus.req0_a;
        ew = (wn == 1) ? bus.req1_w : bus.req0_w;
        step();
        txn(wn, ea, ew, 0, 0, 0, 0, 0, 0);
      end
    end

`ifdef CAMAC_CYCLE_TIMEOUT_EN
    // requester 1 with rdy never arriving
    bus.rdy = 1'b0; bus.req1_a = 2'd1; bus.req1_w = 1'b0; bus.req1 = 1'b1;
    step();
    txn(1, 2'd1, 1'b0, TMO - 2, 0, 0, 0, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
